// File: rtl/video_out_ctrl.sv
// video_out_ctrl: video timing generator with a mode sequencer that switches ypbpr_en only at the vsync leading edge, then mutes for a settle period
module video_out_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int MUTE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        ypbpr_req,
    output logic [11:0] hcount,
    output logic [10:0] vcount,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        csync,
    output logic        frame_start,
    output logic        ypbpr_en,
    output logic        mute,
    output logic        busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int VS_BEG  = V_ACTIVE + V_FP;

    typedef enum logic [1:0] {RUN, PEND, MUTE} state_t;

    state_t      state_q, state_d;
    logic [11:0] hcount_q, hcount_d, h_nxt;
    logic [10:0] vcount_q, vcount_d, v_nxt;
    logic [3:0]  mute_cnt_q, mute_cnt_d;
    logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, csync_q, csync_d;
    logic        frame_start_q, frame_start_d, ypbpr_en_q, ypbpr_en_d, mute_q, mute_d;
    logic        fs_tick, vs_edge;

    // Decode from the next-count values so the sync flags line up with the counters.
    always_comb begin
        h_nxt         = (hcount_q == 12'(H_TOTAL - 1)) ? '0 : hcount_q + 12'd1;
        v_nxt         = (hcount_q != 12'(H_TOTAL - 1)) ? vcount_q :
                        (vcount_q == 11'(V_TOTAL - 1)) ? '0 : vcount_q + 11'd1;
        fs_tick       = ce_pix && h_nxt == '0 && v_nxt == '0;
        vs_edge       = ce_pix && h_nxt == '0 && v_nxt == 11'(VS_BEG);
        hcount_d      = ce_pix ? h_nxt : hcount_q;
        vcount_d      = ce_pix ? v_nxt : vcount_q;
        de_d          = ce_pix ? (h_nxt < 12'(H_ACTIVE) && v_nxt < 11'(V_ACTIVE)) : de_q;
        hsync_d       = ce_pix ? (h_nxt >= 12'(HS_BEG) && h_nxt < 12'(HS_BEG + H_SYNC)) : hsync_q;
        vsync_d       = ce_pix ? (v_nxt >= 11'(VS_BEG) && v_nxt < 11'(VS_BEG + V_SYNC)) : vsync_q;
        csync_d       = hsync_d ^ vsync_d;
        frame_start_d = fs_tick;
    end

    always_comb begin
        state_d    = state_q;
        ypbpr_en_d = ypbpr_en_q;
        mute_d     = mute_q;
        mute_cnt_d = mute_cnt_q;
        if (ce_pix) begin
            case (state_q)
                RUN:  state_d = (ypbpr_req != ypbpr_en_q) ? PEND : RUN;
                PEND: begin
                    if (ypbpr_req == ypbpr_en_q) begin
                        state_d = RUN;
                    end else if (vs_edge) begin
                        ypbpr_en_d = ypbpr_req;
                        mute_d     = 1'b1;
                        mute_cnt_d = 4'(MUTE_FRAMES);
                        state_d    = MUTE;
                    end
                end
                MUTE: begin
                    if (fs_tick) begin
                        mute_cnt_d = mute_cnt_q - 4'd1;
                        mute_d     = mute_cnt_q != 4'd1;
                        state_d    = (mute_cnt_q == 4'd1) ? RUN : MUTE;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            hcount_q      <= '0;
            vcount_q      <= '0;
            mute_cnt_q    <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            csync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            ypbpr_en_q    <= 1'b0;
            mute_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            mute_cnt_q    <= mute_cnt_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            csync_q       <= csync_d;
            frame_start_q <= frame_start_d;
            ypbpr_en_q    <= ypbpr_en_d;
            mute_q        <= mute_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign csync       = csync_q;
    assign frame_start = frame_start_q;
    assign ypbpr_en    = ypbpr_en_q;
    assign mute        = mute_q;
    assign busy        = state_q != RUN;
endmodule

// File: tb/tb_video_out_ctrl.sv
// tb_video_out_ctrl: table vectors, directed mode-switch sequences and random stimulus
// checked every clock against a frame-position reference model.
module tb_video_out_ctrl;
    logic        clk = 1'b0, reset = 1'b1, ce_pix = 1'b0, ypbpr_req = 1'b0;
    logic [11:0] hcount;
    logic [10:0] vcount;
    logic        de, hsync, vsync, csync, frame_start, ypbpr_en, mute, busy;

    video_out_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .MUTE_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .ypbpr_req(ypbpr_req),
        .hcount(hcount), .vcount(vcount), .de(de), .hsync(hsync), .vsync(vsync),
        .csync(csync), .frame_start(frame_start), .ypbpr_en(ypbpr_en),
        .mute(mute), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    // Model: position within the 14x7 frame as a plain tick count, plus mode bookkeeping.
    int n = 0, m_h = 0, m_v = 0, m_de = 0, m_hs = 0, m_vs = 0, m_fs = 0;
    int m_en = 0, pend = 0, left = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic c, input logic q);
        if (r) begin
            n = 0; m_h = 0; m_v = 0; m_de = 0; m_hs = 0; m_vs = 0; m_fs = 0;
            m_en = 0; pend = 0; left = 0;
        end else if (c) begin
            n    = (n + 1) % 98;
            m_h  = n % 14;
            m_v  = n / 14;
            m_de = int'(m_h < 8 && m_v < 4);
            m_hs = int'(m_h == 10 || m_h == 11);
            m_vs = int'(m_v == 5);
            m_fs = int'(n == 0);
            if (left > 0) begin
                if (m_fs != 0) left--;
            end else if (pend == 0) begin
                pend = int'(int'(q) != m_en);
            end else if (int'(q) == m_en) begin
                pend = 0;
            end else if (m_h == 0 && m_v == 5) begin
                m_en = int'(q); left = 2; pend = 0;
            end
        end else begin
            m_fs = 0;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic q);
        reset = r; ce_pix = c; ypbpr_req = q;
        @(posedge clk);
        model(r, c, q);
        #1;
        cyc++;
        chk("hcount", int'(hcount), m_h);
        chk("vcount", int'(vcount), m_v);
        chk("de", int'(de), m_de);
        chk("hsync", int'(hsync), m_hs);
        chk("vsync", int'(vsync), m_vs);
        chk("csync", int'(csync), m_hs ^ m_vs);
        chk("frame_start", int'(frame_start), m_fs);
        chk("ypbpr_en", int'(ypbpr_en), m_en);
        chk("mute", int'(mute), int'(left > 0));
        chk("busy", int'(busy), int'(pend != 0 || left > 0));
    endtask

    task automatic run(input int k, input logic q);
        for (int i = 0; i < k; i++) step(1'b0, 1'b1, q);
    endtask

    typedef struct {int ticks; int h; int v; int de; int hs; int vs; int fs;} vec_t;
    vec_t tbl[11];
    int fs_at[$];

    initial begin
        tbl = '{
            '{0, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 1, 0, 0, 0}, '{10, 10, 0, 0, 1, 0, 0},
            '{11, 11, 0, 0, 1, 0, 0}, '{12, 12, 0, 0, 0, 0, 0}, '{14, 0, 1, 1, 0, 0, 0},
            '{56, 0, 4, 0, 0, 0, 0}, '{70, 0, 5, 0, 0, 1, 0}, '{83, 13, 5, 0, 0, 1, 0},
            '{84, 0, 6, 0, 0, 0, 0}, '{98, 0, 0, 1, 0, 0, 1}
        };
        foreach (tbl[i]) begin
            step(1'b1, 1'b1, 1'b0);
            run(tbl[i].ticks, 1'b0);
            chk("tbl_h", int'(hcount), tbl[i].h);
            chk("tbl_v", int'(vcount), tbl[i].v);
            chk("tbl_de", int'(de), tbl[i].de);
            chk("tbl_hs", int'(hsync), tbl[i].hs);
            chk("tbl_vs", int'(vsync), tbl[i].vs);
            chk("tbl_cs", int'(csync), tbl[i].hs ^ tbl[i].vs);
            chk("tbl_fs", int'(frame_start), tbl[i].fs);
        end
        // Switch requested at vcount=1: applied at h0/v5, muted until 2nd frame start.
        step(1'b1, 1'b1, 1'b0);
        run(14, 1'b0);
        run(1, 1'b1);
        chk("t2_busy_rise", int'(busy), 1);
        run(54, 1'b1);
        chk("t2_en_before", int'(ypbpr_en), 0);
        run(1, 1'b1);
        chk("t2_en_edge", int'(ypbpr_en), 1);
        chk("t2_mute_edge", int'(mute), 1);
        run(28, 1'b1);
        chk("t2_mute_fs1", int'(mute), 1);
        run(98, 1'b1);
        chk("t2_mute_fs2", int'(mute), 0);
        chk("t2_busy_fs2", int'(busy), 0);
        chk("t2_en_final", int'(ypbpr_en), 1);
        // Cancelled request.
        step(1'b1, 1'b1, 1'b0);
        run(14, 1'b0);
        run(3, 1'b1);
        chk("t3_busy_rise", int'(busy), 1);
        run(3, 1'b0);
        chk("t3_busy_fall", int'(busy), 0);
        run(100, 1'b0);
        chk("t3_en", int'(ypbpr_en), 0);
        chk("t3_mute", int'(mute), 0);
        // Request dropped during MUTE: a second full switch back to 0.
        step(1'b1, 1'b1, 1'b0);
        run(14, 1'b0);
        run(56, 1'b1);
        chk("t4_en_first", int'(ypbpr_en), 1);
        run(196, 1'b0);
        chk("t4_en_second", int'(ypbpr_en), 0);
        chk("t4_mute_second", int'(mute), 1);
        run(126, 1'b0);
        chk("t4_mute_end", int'(mute), 0);
        chk("t4_busy_end", int'(busy), 0);
        // Reset during MUTE with the request still high.
        step(1'b1, 1'b1, 1'b0);
        run(14, 1'b0);
        run(60, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t6_h", int'(hcount), 0);
        chk("t6_en", int'(ypbpr_en), 0);
        chk("t6_mute", int'(mute), 0);
        chk("t6_busy", int'(busy), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("t6_busy_rerise", int'(busy), 1);
        // Pixel enable every third clock.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 900; i++) begin
            step(1'b0, (i % 3) == 0, 1'b0);
            if (frame_start) fs_at.push_back(i);
        end
        chk("t5_fs_count", fs_at.size(), 3);
        for (int i = 1; i < fs_at.size(); i++) chk("t5_fs_period", fs_at[i] - fs_at[i-1], 294);
        // Random enables, requests and occasional resets.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) ypbpr_req = ~ypbpr_req;
            step($urandom_range(0, 799) == 0, $urandom_range(0, 3) != 0, ypbpr_req);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
